memory_responder: RTL

Memory-side responder for the sequencer's memory interface: the sequencer drives MEM_En (active low), MEM_Wr (1 = read, 0 = write) and an address, and this block services the request.
- Single-port synchronous word RAM.
- Programmable wait states.
- Registered read data that holds its last value when idle.
- One-cycle Ready completion pulse back to the sequencer.
- Sits between the address mux / register-file data path and the sequence controller.

---
 rtl/memory_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - single-port word RAM responder with wait states and Ready pulse
// Optional MEM_BOUNDS_EN: out-of-range addresses (>= Depth) are suppressed and flagged on Err.
module memory_responder #(
    parameter int DataWidth  = 16,
    parameter int AddrWidth  = 8,
    parameter int Depth      = 256,
    parameter int WaitStates = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 MEM_En,
    input  logic                 MEM_Wr,
    input  logic [AddrWidth-1:0] Addr,
    input  logic [DataWidth-1:0] DataIn,
    output logic [DataWidth-1:0] DataOut,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Err
);

    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [3:0] WaitLoad = 4'(WaitStates);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           wait_cnt;
    logic                 rd_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [IdxWidth-1:0]  idx;
    logic                 in_range;

    logic [DataWidth-1:0] mem [0:Depth-1];

    assign idx = addr_q[IdxWidth-1:0];

`ifdef MEM_BOUNDS_EN
    logic err_q;

    assign in_range = (int'(addr_q) < Depth);
    assign Err      = (state == DONE) && err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (state == ACCESS) begin
            err_q <= !in_range;
        end
    end
`else
    assign in_range = 1'b1;
    assign Err      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        Ready     = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (!MEM_En) begin
                    state_nxt = (WaitStates > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                Busy = 1'b1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                Busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                Ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            DataOut  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (!MEM_En) wait_cnt <= WaitLoad;
                WAIT:    wait_cnt <= wait_cnt - 4'd1;
                ACCESS:  if (rd_q) DataOut <= in_range ? mem[idx] : '0;
                default: ;
            endcase
        end
    end

    // Request fields are only meaningful once captured, so they need no reset.
    always_ff @(posedge Clk) begin
        if (state == IDLE && !MEM_En) begin
            addr_q <= Addr;
            rd_q   <= MEM_Wr;
            data_q <= DataIn;
        end
    end

    // A Reset on the committing edge discards the write.
    always_ff @(posedge Clk) begin
        if (!Reset && state == ACCESS && !rd_q && in_range) begin
            mem[idx] <= data_q;
        end
    end

endmodule
